rv_pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the uRV core: generates per-stage stall and kill strobes from per-stage stall requests, a branch-taken strobe and a full-pipeline flush, for any stage count. Replaces the hard-wired stall/kill equations and ad-hoc branch-shadow registers in the CPU top level. Adds a stall watchdog with culprit capture and a stall-cycle performance counter. Sits in the CPU top level between the fetch, decode, execute and writeback stages.

---
 rtl/rv_pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_rv_pipe_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_ctrl.sv
// uRV pipeline control: per-stage stall/kill from stall requests, branch and
// flush, plus a stall watchdog with culprit capture and a stall-cycle counter.
module rv_pipe_ctrl #(
    parameter int                  G_STAGES     = 4,
    parameter int                  G_BRA_STAGE  = 2,
    parameter logic [G_STAGES-1:0] G_SELF_STALL = G_STAGES'(4'b0100),
    parameter int                  G_WDT_WIDTH  = 6,
    parameter int                  SW           = (G_STAGES > 2) ? $clog2(G_STAGES) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [G_STAGES-1:0] stall_req_i,
    input  logic                bra_i,
    input  logic                flush_i,
    input  logic                wdt_clr_i,
    output logic [G_STAGES-1:0] stall_o,
    output logic [G_STAGES-1:0] kill_o,
    output logic                wdt_timeout_o,
    output logic [SW-1:0]       wdt_stage_o,
    output logic [31:0]         perf_stall_cycles_o
);

    localparam logic [G_WDT_WIDTH-1:0] L_PRE = {{(G_WDT_WIDTH-1){1'b1}}, 1'b0};

    logic [G_BRA_STAGE-1:0] r_sh;
    logic [G_WDT_WIDTH-1:0] r_cnt;
    logic                   r_first;
    logic                   r_to;
    logic [SW-1:0]          r_stage;
    logic [31:0]            r_perf;

    logic [G_STAGES-1:0]    w_stall;
    logic [G_STAGES-1:0]    w_kill;
    logic [G_STAGES-1:0]    w_shx;
    logic [G_BRA_STAGE-1:0] w_sh_nxt;
    logic                   w_acc;
    logic [SW-1:0]          w_hi;

    always_comb begin
        w_stall = '0;
        for (int i = 0; i < G_STAGES; i++) begin
            w_stall[i] = stall_req_i[i] & G_SELF_STALL[i];
            for (int j = i + 1; j < G_STAGES; j++) begin
                w_stall[i] = w_stall[i] | stall_req_i[j];
            end
        end
    end

    // Shadow padded to full width so stage indices above the branch stage read 0
    always_comb begin
        w_shx = '0;
        w_shx[G_BRA_STAGE-1:0] = r_sh;
    end

    always_comb begin
        w_sh_nxt    = '0;
        w_sh_nxt[0] = bra_i;
        for (int k = 1; k < G_BRA_STAGE; k++) begin
            w_sh_nxt[k] = r_sh[k-1];
        end
    end

    always_comb begin
        w_kill = '0;
        w_acc  = bra_i;
        for (int i = 0; i < G_STAGES; i++) begin
            if (i <= G_BRA_STAGE) begin
                w_kill[i] = w_acc;
            end
            w_acc = w_acc | w_shx[i];
        end
        if (rst_i || flush_i) begin
            w_kill = '1;
        end
    end

    always_comb begin
        w_hi = '0;
        for (int j = 0; j < G_STAGES; j++) begin
            if (stall_req_i[j]) begin
                w_hi = SW'(j);
            end
        end
    end

    // r_first marks the first cycle the watchdog counter sits at saturation
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sh    <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
            r_to    <= 1'b0;
            r_stage <= '0;
            r_perf  <= '0;
        end else begin
            if (flush_i) begin
                r_sh <= '1;
            end else if (!w_stall[G_BRA_STAGE]) begin
                r_sh <= w_sh_nxt;
            end
            if (stall_req_i == '0) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_first <= (|stall_req_i) && (r_cnt == L_PRE);
            if (wdt_clr_i) begin
                r_to    <= 1'b0;
                r_stage <= '0;
            end else if (r_first && !r_to) begin
                r_to    <= 1'b1;
                r_stage <= w_hi;
            end
            if (w_stall[0]) begin
                r_perf <= r_perf + 32'd1;
            end
        end
    end

    assign stall_o             = rst_i ? '0 : w_stall;
    assign kill_o              = w_kill;
    assign wdt_timeout_o       = r_to;
    assign wdt_stage_o         = r_stage;
    assign perf_stall_cycles_o = r_perf;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Randomized and directed bench for rv_pipe_ctrl against a queue-based
// model of branch ages, stall run lengths and counters.
module tb_rv_pipe_ctrl;

    localparam int          B    = 2;
    localparam logic [3:0]  SELF = 4'b0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic        bra = 1'b0;
    logic        flush = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  stall, kill;
    logic        to;
    logic [1:0]  stage;
    logic [31:0] perf;

    logic        rst6 = 1'b1;
    logic [5:0]  req6 = '0;
    logic        bra6 = 1'b0;
    logic [5:0]  stall6, kill6;
    logic        to6;
    logic [2:0]  stage6;
    logic [31:0] perf6;

    int n_chk = 0;
    int n_pass = 0;

    int          m_q[$];
    int          m_prior = 0;
    logic        m_to = 1'b0;
    logic [1:0]  m_stage = '0;
    logic [31:0] m_perf = '0;

    always #5 clk = ~clk;

    rv_pipe_ctrl dut (
        .clk_i(clk), .rst_i(rst), .stall_req_i(req), .bra_i(bra),
        .flush_i(flush), .wdt_clr_i(clr), .stall_o(stall), .kill_o(kill),
        .wdt_timeout_o(to), .wdt_stage_o(stage), .perf_stall_cycles_o(perf)
    );

    rv_pipe_ctrl #(
        .G_STAGES(6), .G_BRA_STAGE(4), .G_SELF_STALL(6'b010000)
    ) dut6 (
        .clk_i(clk), .rst_i(rst6), .stall_req_i(req6), .bra_i(bra6),
        .flush_i(1'b0), .wdt_clr_i(1'b0), .stall_o(stall6), .kill_o(kill6),
        .wdt_timeout_o(to6), .wdt_stage_o(stage6), .perf_stall_cycles_o(perf6)
    );

    function automatic logic [3:0] m_stall_f(input logic [3:0] r);
        logic [3:0] s;
        s = '0;
        if (rst) return s;
        for (int i = 0; i < 4; i++)
            s[i] = ((r >> (i + 1)) != 0) || (r[i] && SELF[i]);
        return s;
    endfunction

    // A branch of age a has left the branch stage a advancing cycles ago
    function automatic logic [3:0] m_kill_f();
        logic [3:0] k;
        k = '0;
        if (rst || flush) return 4'hF;
        for (int i = 0; i <= B; i++) begin
            k[i] = bra;
            foreach (m_q[n]) if (m_q[n] <= i) k[i] = 1'b1;
        end
        return k;
    endfunction

    task automatic m_step();
        logic [3:0] s;
        int nq[$];
        int h;
        if (rst) begin
            m_q.delete();
            m_prior = 0; m_to = 0; m_stage = '0; m_perf = '0;
            return;
        end
        s = m_stall_f(req);
        if (s[0]) m_perf = m_perf + 1;
        h = 0;
        for (int j = 0; j < 4; j++) if (req[j]) h = j;
        if (clr) begin
            m_to = 0; m_stage = '0;
        end else if (m_prior == 63 && !m_to) begin
            m_to = 1; m_stage = 2'(h);
        end
        m_prior = (req != 0) ? m_prior + 1 : 0;
        if (flush) begin
            m_q.delete();
            for (int a = 1; a <= B; a++) m_q.push_back(a);
        end else if (!s[B]) begin
            foreach (m_q[n]) if (m_q[n] < B) nq.push_back(m_q[n] + 1);
            if (bra) nq.push_back(1);
            m_q = nq;
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req = 4'hF; bra = 1;
        #1;
        n_chk++; if (stall !== 4'h0) $display("FAIL rst_stall got=%b exp=0000", stall); else n_pass++;
        n_chk++; if (kill !== 4'hF) $display("FAIL rst_kill got=%b exp=1111", kill); else n_pass++;
        tick(); tick();
        rst = 0; req = '0; bra = 0;
        #1;
        n_chk++; if (kill !== 4'h0) $display("FAIL post_rst_kill got=%b exp=0000", kill); else n_pass++;
        n_chk++; if (to !== 1'b0 || stage !== 2'd0) $display("FAIL rst_wdt got=%b/%0d exp=0/0", to, stage); else n_pass++;
        n_chk++; if (perf !== 32'd0) $display("FAIL rst_perf got=%0d exp=0", perf); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] p0;
        p0 = perf;
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++; if (stall !== 4'b0111) $display("FAIL stall_ex got=%b exp=0111", stall); else n_pass++;
            tick();
        end
        n_chk++; if (perf - p0 !== 32'd3) $display("FAIL perf3 got=%0d exp=3", perf - p0); else n_pass++;
        n_chk++; if (perf !== m_perf) $display("FAIL perf_model got=%0d exp=%0d", perf, m_perf); else n_pass++;
        req = 4'b0010;
        #1;
        n_chk++; if (stall !== 4'b0001) $display("FAIL stall_id got=%b exp=0001", stall); else n_pass++;
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_branch();
        logic [3:0] seq [4];
        seq[0] = 4'b0111; seq[1] = 4'b0110; seq[2] = 4'b0100; seq[3] = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            bra = (c == 0);
            #1;
            n_chk++; if (kill !== seq[c]) $display("FAIL bra_seq%0d got=%b exp=%b", c, kill, seq[c]); else n_pass++;
            tick();
        end
    endtask

    task automatic test_branch_stall();
        logic [3:0] seq [6];
        seq[0] = 4'b0111; seq[1] = 4'b0110; seq[2] = 4'b0110;
        seq[3] = 4'b0110; seq[4] = 4'b0100; seq[5] = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            bra = (c == 0);
            req = (c == 1 || c == 2) ? 4'b1000 : 4'b0000;
            #1;
            n_chk++; if (kill !== seq[c]) $display("FAIL brst_seq%0d got=%b exp=%b", c, kill, seq[c]); else n_pass++;
            n_chk++; if (kill !== m_kill_f()) $display("FAIL brst_model%0d got=%b exp=%b", c, kill, m_kill_f()); else n_pass++;
            tick();
        end
        req = '0;
    endtask

    task automatic test_flush();
        req = 4'b0100; bra = 1; flush = 1;
        #1;
        n_chk++; if (kill !== 4'b1111) $display("FAIL flush_kill got=%b exp=1111", kill); else n_pass++;
        tick();
        flush = 0;
        #1;
        n_chk++; if (kill !== 4'b0111) $display("FAIL flush_next got=%b exp=0111", kill); else n_pass++;
        tick();
        req = '0; bra = 0;
        tick(); tick(); tick();
        #1;
        n_chk++; if (kill !== 4'b0000) $display("FAIL flush_done got=%b exp=0000", kill); else n_pass++;
    endtask

    task automatic test_wdt();
        req = 4'b1000;
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (n == 63) begin
                n_chk++; if (to !== 1'b0) $display("FAIL wdt_early got=%b exp=0", to); else n_pass++;
            end
            if (n == 64) begin
                n_chk++; if (to !== 1'b1) $display("FAIL wdt_rise got=%b exp=1", to); else n_pass++;
                n_chk++; if (stage !== 2'd3) $display("FAIL wdt_stage got=%0d exp=3", stage); else n_pass++;
            end
        end
        clr = 1;
        tick();
        clr = 0;
        n_chk++; if (to !== 1'b0 || stage !== 2'd0) $display("FAIL wdt_clr got=%b/%0d exp=0/0", to, stage); else n_pass++;
        for (int n = 0; n < 8; n++) tick();
        n_chk++; if (to !== 1'b0) $display("FAIL wdt_stay got=%b exp=0", to); else n_pass++;
        n_chk++; if (perf !== m_perf) $display("FAIL wdt_perf got=%0d exp=%0d", perf, m_perf); else n_pass++;
        req = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (c >= 200 && c < 300)
                req = 4'($urandom_range(1, 15));
            else
                req = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            bra   = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 19) == 0);
            clr   = ($urandom_range(0, 39) == 0);
            #1;
            n_chk++; if (stall !== m_stall_f(req)) $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, m_stall_f(req)); else n_pass++;
            n_chk++; if (kill !== m_kill_f()) $display("FAIL rnd_kill c=%0d got=%b exp=%b", c, kill, m_kill_f()); else n_pass++;
            tick();
            n_chk++; if (to !== m_to || stage !== m_stage) $display("FAIL rnd_wdt c=%0d got=%b/%0d exp=%b/%0d", c, to, stage, m_to, m_stage); else n_pass++;
            n_chk++; if (perf !== m_perf) $display("FAIL rnd_perf c=%0d got=%0d exp=%0d", c, perf, m_perf); else n_pass++;
        end
        req = '0; bra = 0; flush = 0; clr = 0;
        tick();
    endtask

    task automatic test_reset6();
        rst6 = 0; req6 = '0; bra6 = 1;
        #1;
        n_chk++; if (kill6 !== 6'b011111) $display("FAIL k6_t0 got=%b exp=011111", kill6); else n_pass++;
        tick();
        bra6 = 0;
        #1;
        n_chk++; if (kill6 !== 6'b011110) $display("FAIL k6_t1 got=%b exp=011110", kill6); else n_pass++;
        tick();
        #1;
        n_chk++; if (kill6 !== 6'b011100) $display("FAIL k6_t2 got=%b exp=011100", kill6); else n_pass++;
        rst6 = 1; req6 = 6'b100000;
        #1;
        n_chk++; if (kill6 !== 6'b111111) $display("FAIL k6_rst got=%b exp=111111", kill6); else n_pass++;
        n_chk++; if (stall6 !== 6'b000000) $display("FAIL s6_rst got=%b exp=000000", stall6); else n_pass++;
        tick();
        rst6 = 0; req6 = '0;
        #1;
        n_chk++; if (kill6 !== 6'b000000) $display("FAIL k6_post got=%b exp=000000", kill6); else n_pass++;
        tick();
        n_chk++; if (kill6 !== 6'b000000) $display("FAIL k6_post2 got=%b exp=000000", kill6); else n_pass++;
        n_chk++; if (to6 !== 1'b0 || stage6 !== 3'd0 || perf6 !== 32'd0) $display("FAIL w6_post got=%b/%0d/%0d exp=0/0/0", to6, stage6, perf6); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_branch_stall();
        test_flush();
        test_wdt();
        test_random();
        test_reset6();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
